// File: rtl/conv_pool_addr_gen_if.sv
// Read-address channel between the conv/pool address generator and the feature-map RAM port.
// The master presents an address plus window/pool/channel tags; the slave accepts with addr_ready.
interface conv_pool_addr_gen_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              win_last;
  logic              pool_last;
  logic              ch_last;

  modport master (
    output addr, addr_valid, win_last, pool_last, ch_last,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_valid, win_last, pool_last, ch_last,
    output addr_ready
  );
endinterface

// File: rtl/conv_pool_addr_gen.sv
// Read-address generator for the conv+maxpool feature-map buffer: walks every kernel tap of every
// conv window, grouped by pooling window and channel, one flat address per accepted beat.
module conv_pool_addr_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int POOL   = 2,
  parameter int CH     = 1,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base_addr,
  conv_pool_addr_gen_if.master rd,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
  localparam int PW    = OUT_W / POOL;
  localparam int PH    = OUT_H / POOL;

  localparam int KW  = (K    > 1) ? $clog2(K)    : 1;
  localparam int PLW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int PCW = (PW   > 1) ? $clog2(PW)   : 1;
  localparam int PRW = (PH   > 1) ? $clog2(PH)   : 1;
  localparam int CHW = (CH   > 1) ? $clog2(CH)   : 1;
  localparam int AW  = ADDR_W + 8;

  localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
  localparam logic [PLW-1:0] P_MAX  = PLW'(POOL - 1);
  localparam logic [PCW-1:0] PC_MAX = PCW'(PW - 1);
  localparam logic [PRW-1:0] PR_MAX = PRW'(PH - 1);
  localparam logic [CHW-1:0] CH_MAX = CHW'(CH - 1);

  localparam logic [AW-1:0] IMG_W_C  = AW'(IMG_W);
  localparam logic [AW-1:0] PLANE_C  = AW'(IMG_W * IMG_H);
  localparam logic [AW-1:0] POOL_C   = AW'(POOL);
  localparam logic [AW-1:0] STRIDE_C = AW'(STRIDE);

  // A geometry that does not tile exactly would silently skip border pixels.
  if ((IMG_W - K) % STRIDE != 0 || (IMG_H - K) % STRIDE != 0 ||
      OUT_W % POOL != 0 || OUT_H % POOL != 0) begin : g_bad_geometry
    $error("conv_pool_addr_gen: image/kernel/stride/pool geometry does not tile exactly");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [KW-1:0]     kj, ki;
  logic [PLW-1:0]    pj, pi;
  logic [PCW-1:0]    pc;
  logic [PRW-1:0]    pr;
  logic [CHW-1:0]    ch;

  logic running;
  logic kj_t, ki_t, pj_t, pi_t, pc_t, pr_t, ch_t;
  logic beat, c_ki, c_pj, c_pi, c_pc, c_pr, c_ch, last_beat;
  logic win_last, pool_last;
  logic [AW-1:0] row, col;

  assign running = (state == S_RUN);

  assign kj_t = (kj == K_MAX);
  assign ki_t = (ki == K_MAX);
  assign pj_t = (pj == P_MAX);
  assign pi_t = (pi == P_MAX);
  assign pc_t = (pc == PC_MAX);
  assign pr_t = (pr == PR_MAX);
  assign ch_t = (ch == CH_MAX);

  // Carry ripples outward only on an accepted beat; each stage enables the next counter.
  assign beat      = running & rd.addr_ready;
  assign c_ki      = beat & kj_t;
  assign c_pj      = c_ki & ki_t;
  assign c_pi      = c_pj & pj_t;
  assign c_pc      = c_pi & pi_t;
  assign c_pr      = c_pc & pc_t;
  assign c_ch      = c_pr & pr_t;
  assign last_beat = c_ch & ch_t;

  assign row = (AW'(pr) * POOL_C + AW'(pi)) * STRIDE_C + AW'(ki);
  assign col = (AW'(pc) * POOL_C + AW'(pj)) * STRIDE_C + AW'(kj);

  assign win_last  = running & kj_t & ki_t;
  assign pool_last = win_last & pj_t & pi_t;

  // Outputs decode registers only, so addr_ready never reaches them combinationally.
  assign rd.addr       = running ? ADDR_W'(AW'(base_q) + AW'(ch) * PLANE_C + row * IMG_W_C + col)
                                 : '0;
  assign rd.addr_valid = running;
  assign rd.win_last   = win_last;
  assign rd.pool_last  = pool_last;
  assign rd.ch_last    = pool_last & pc_t & pr_t;
  assign busy          = running;
  assign done          = (state == S_DONE);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= S_IDLE;
      base_q <= '0;
      kj     <= '0;
      ki     <= '0;
      pj     <= '0;
      pi     <= '0;
      pc     <= '0;
      pr     <= '0;
      ch     <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            base_q <= base_addr;
            kj     <= '0;
            ki     <= '0;
            pj     <= '0;
            pi     <= '0;
            pc     <= '0;
            pr     <= '0;
            ch     <= '0;
          end
        end
        S_RUN: begin
          if (last_beat) state <= S_DONE;
          if (beat) kj <= kj_t ? '0 : kj + KW'(1);
          if (c_ki) ki <= ki_t ? '0 : ki + KW'(1);
          if (c_pj) pj <= pj_t ? '0 : pj + PLW'(1);
          if (c_pi) pi <= pi_t ? '0 : pi + PLW'(1);
          if (c_pc) pc <= pc_t ? '0 : pc + PCW'(1);
          if (c_pr) pr <= pr_t ? '0 : pr + PRW'(1);
          if (c_ch) ch <= ch_t ? '0 : ch + CHW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
